// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtractor step per clock, LSB first,
// with valid/ready handshakes on operand intake and result delivery.
module serial_sub #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               br_q, br_d;
    logic               bout_q, bout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // One full-subtractor cell evaluated on the current LSBs.
    logic d_bit, br_nxt;
    logic [WIDTH-1:0] res_shift;
    assign d_bit     = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_nxt    = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    // Shift right with the new bit entering at the MSB; written as an OR so it
    // also holds for WIDTH=1.
    assign res_shift = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT);
    // Separate output registers so diff/b_out keep the last result while the
    // working registers are reused by the next operation.
    assign diff      = diff_q;
    assign b_out     = bout_q;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update for IDLE/SHIFT/DONE.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = b_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = br_nxt;
                res_d = res_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d  = res_shift;
                    bout_d  = br_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: an 8-bit and a 1-bit instance, expected
// results queued at operand acceptance and popped by per-instance monitors.
module tb_serial_sub;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // 8-bit instance signals
    logic       iv8 = 1'b0, bi8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ir8, ov8, bo8, busy8, or8;
    logic [7:0] d8;
    logic       rnd_bp = 1'b0, rnd_or = 1'b1, or_man = 1'b1;
    assign or8 = rnd_bp ? rnd_or : or_man;

    // 1-bit instance signals
    logic iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bi1 = 1'b0, or1 = 1'b1;
    logic ir1, ov1, bo1, busy1;
    logic [0:0] d1;

    exp_t q8[$];
    exp_t q1[$];
    logic seen8 = 1'b0, seen1 = 1'b0;

    serial_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .b_in(bi8), .out_valid(ov8), .out_ready(or8), .diff(d8), .b_out(bo8), .busy(busy8)
    );

    serial_sub #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .b_in(bi1), .out_valid(ov1), .out_ready(or1), .diff(d1), .b_out(bo1), .busy(busy1)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer backpressure for the 8-bit instance when enabled.
    always @(posedge clk) begin
        #1;
        rnd_or = ($urandom_range(0, 3) != 0);
    end

    // Reference: plain unsigned arithmetic modulo 2^w.
    function automatic exp_t model(input int av, input int bv, input int bin, input int w);
        exp_t e;
        int m, r;
        m = 1 << w;
        r = av - bv - bin;
        if (r < 0) r = r + m;
        e.d  = 8'(r);
        e.bo = (av < bv + bin);
        e.t  = 0;
        return e;
    endfunction

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q8.delete();
            seen8 = 1'b0;
        end else if (ov8) begin
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL w8_unexpected: out_valid with empty scoreboard, diff=%h", d8);
            end else begin
                if (!seen8) begin
                    checks++;
                    if (cyc - q8[0].t != 8) begin
                        errors++;
                        $display("FAIL w8_latency: got %0d cycles, want 8", cyc - q8[0].t);
                    end
                    seen8 = 1'b1;
                end
                if (or8) begin
                    e = q8.pop_front();
                    checks++;
                    if (d8 !== e.d || bo8 !== e.bo) begin
                        errors++;
                        $display("FAIL w8_result: diff=%h b_out=%b, want diff=%h b_out=%b", d8, bo8, e.d, e.bo);
                    end
                    seen8 = 1'b0;
                end
            end
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q1.delete();
            seen1 = 1'b0;
        end else if (ov1) begin
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL w1_unexpected: out_valid with empty scoreboard");
            end else begin
                if (!seen1) begin
                    checks++;
                    if (cyc - q1[0].t != 1) begin
                        errors++;
                        $display("FAIL w1_latency: got %0d cycles, want 1", cyc - q1[0].t);
                    end
                    seen1 = 1'b1;
                end
                if (or1) begin
                    e = q1.pop_front();
                    checks++;
                    if (d1[0] !== e.d[0] || bo1 !== e.bo) begin
                        errors++;
                        $display("FAIL w1_result: d=%b b_out=%b, want d=%b b_out=%b", d1[0], bo1, e.d[0], e.bo);
                    end
                    seen1 = 1'b0;
                end
            end
        end
    end

    // Present one operand set, wait for acceptance and queue the expectation.
    task automatic send(input int w, input int av, input int bv, input int bin, input exp_t ex);
        int n;
        exp_t e;
        @(posedge clk); #1;
        if (w == 8) begin a8 = av[7:0]; b8 = bv[7:0]; bi8 = bin[0]; iv8 = 1'b1; end
        else begin a1 = av[0]; b1 = bv[0]; bi1 = bin[0]; iv1 = 1'b1; end
        n = 0;
        forever begin
            @(negedge clk);
            if ((w == 8) ? ir8 : ir1) break;
            n++;
            if (n > 200) begin
                errors++;
                $display("FAIL send_timeout: in_ready=0 after %0d cycles, want 1", n);
                iv8 = 1'b0; iv1 = 1'b0;
                return;
            end
        end
        e   = ex;
        e.t = cyc + 1;
        if (w == 8) q8.push_back(e); else q1.push_back(e);
        @(posedge clk); #1;
        iv8 = 1'b0; iv1 = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q8.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d/%0d results outstanding, want 0", name, q8.size(), q1.size());
        end
    endtask

    initial begin
        int av, bv, bin, n;
        logic [15:0] tt;
        logic [1:0]  ent;
        exp_t        e;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_diff", 32'(d8), 32'd0);
        chk("rst_b_out", 32'(bo8), 32'd0);
        chk("rst_w1_ready", 32'(ir1), 32'd1);
        #2 rst_n = 1'b1;

        // Directed 8-bit cases
        send(8, 'h05, 'h03, 0, model('h05, 'h03, 0, 8));
        chk("busy_in_shift", 32'(busy8), 32'd1);
        chk("ready_in_shift", 32'(ir8), 32'd0);
        send(8, 'h00, 'h01, 0, model('h00, 'h01, 0, 8));
        send(8, 'hFF, 'hFF, 1, model('hFF, 'hFF, 1, 8));
        send(8, 'h80, 'h7F, 1, model('h80, 'h7F, 1, 8));
        drain("directed");

        // Backpressure: result held while out_ready is low
        or_man = 1'b0;
        send(8, 'h3C, 'h1A, 0, model('h3C, 'h1A, 0, 8));
        n = 0;
        while (!ov8 && n < 50) begin @(negedge clk); n++; end
        chk("bp_valid_seen", 32'(ov8), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {20'd0, ov8, ir8, bo8, 1'b0, d8}, {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22});
            @(negedge clk);
        end
        @(posedge clk); #1 or_man = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_ready", 32'(ir8), 32'd1);
        chk("bp_release_valid", 32'(ov8), 32'd0);
        chk("bp_diff_holds", 32'(d8), 32'h22);

        // Reset in the middle of an operation
        send(8, 'hAA, 'h55, 0, model('hAA, 'h55, 0, 8));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov8), 32'd0);
        chk("mid_rst_diff", 32'(d8), 32'd0);
        chk("mid_rst_b_out", 32'(bo8), 32'd0);
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_ready", 32'(ir8), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        send(8, 'h10, 'h01, 0, model('h10, 'h01, 0, 8));
        drain("post_reset");

        // Randomized traffic with random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            av  = $urandom_range(0, 255);
            bv  = $urandom_range(0, 255);
            bin = $urandom_range(0, 1);
            send(8, av, bv, bin, model(av, bv, bin, 8));
        end
        drain("random");
        rnd_bp = 1'b0;

        // WIDTH=1: full-subtractor truth table, {d,b_out} for {a,b,b_in}=000..111
        tt = 16'b00_11_11_01_10_00_00_11;
        for (int i = 0; i < 8; i++) begin
            ent  = tt[15 - 2*i -: 2];
            e.d  = {7'd0, ent[1]};
            e.bo = ent[0];
            e.t  = 0;
            send(1, (i >> 2) & 1, (i >> 1) & 1, i & 1, e);
        end
        drain("width1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule
